stencil_reader: RTL and testbench
=================================

STENCIL_READER -- requirements
Module: stencil_reader

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 12, pixel width.
REQ-002 The module SHALL have parameter X_WIDTH, default 5, column index width (32 columns).
REQ-003 The module SHALL have parameter Y_WIDTH, default 6, row index width (64 rows).
REQ-004 The module SHALL have parameter ADDR_WIDTH, default X_WIDTH+Y_WIDTH, buffer address width.
REQ-005 The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-007 The module SHALL have port start, input, 1, request one frame scan.
REQ-008 The module SHALL have port continuous, input, 1, restart the scan after each frame while high.
REQ-009 The module SHALL have port rd_address, output, ADDR_WIDTH, read address to the stencil buffer read port.
REQ-010 The module SHALL have port rd_data, input, DATA_WIDTH, combinational read data for rd_address.
REQ-011 The module SHALL have port pix_data, output, DATA_WIDTH, registered pixel value.
REQ-012 The module SHALL have port pix_x, output, X_WIDTH, column of pix_data.
REQ-013 The module SHALL have port pix_y, output, Y_WIDTH, row of pix_data.
REQ-014 The module SHALL have port pix_sof, output, 1, high with pixel (0,0).
REQ-015 The module SHALL have port pix_eol, output, 1, high with the last column of each row.
REQ-016 The module SHALL have port pix_eof, output, 1, high with the last pixel of the frame.
REQ-017 The module SHALL have port pix_valid, output, 1, pixel outputs hold a valid beat.
REQ-018 The module SHALL have port pix_ready, input, 1, downstream accepts the beat.
REQ-019 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-020 The module SHALL have port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-021 Address SHALL be {y, x}, x in the low X_WIDTH bits; scan order row-major, x increments first, 0 to 2^ADDR_WIDTH-1.
REQ-022 FSM SHALL have states IDLE, SCAN, DRAIN.
REQ-023 IDLE: start=1 -> SCAN, rd_address<=0; otherwise stay, rd_address held at 0.
REQ-024 SCAN: when pix_valid=0 or pix_ready=1 (output slot free), register rd_data, x, y and flags into pix_* and set pix_valid=1, then increment rd_address.
REQ-025 SCAN: when slot not free (pix_valid=1, pix_ready=0), rd_address and all pix_* SHALL hold unchanged.
REQ-026 SCAN: when the loaded address is all-ones -> DRAIN; rd_address wraps to 0.
REQ-027 DRAIN: on pix_ready=1, pix_valid<=0 and done<=1 for one cycle; then SCAN if continuous=1 (first pixel loaded next cycle), else IDLE.
REQ-028 Handshake: a beat transfers when pix_valid=1 and pix_ready=1 on the same edge; pix_* SHALL be stable while pix_valid=1 and pix_ready=0.
REQ-029 pix_valid SHALL drop to 0 after a transfer only when no new beat is loaded in the same cycle.
REQ-030 Latency: start sampled at edge N -> pix_valid=1 after edge N+2 with pixel (0,0).
REQ-031 Throughput: with pix_ready held 1, one pixel per cycle; one frame = 2^ADDR_WIDTH beats with no bubbles.
REQ-032 In continuous mode, exactly one bubble cycle (pix_valid=0) SHALL separate frames.
REQ-033 start SHALL be ignored outside IDLE; start and the DRAIN completion in the same cycle SHALL NOT start an extra frame.
REQ-034 Buffer writes during a scan SHALL appear in the output iff written before the edge that loads that address.
REQ-035 done SHALL be 0 in all cycles other than the DRAIN completion cycle.

Reset
REQ-036 reset=1 at any edge, including mid-frame, SHALL force IDLE, rd_address=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_sof=0, pix_eol=0, pix_eof=0, busy=0, done=0.
REQ-037 reset SHALL take priority over start and pix_ready in the same cycle.

Verification
REQ-038 Buffer preloaded mem[a]=a, start pulse, pix_ready=1 -> 2048 beats, pix_data=0..2047 in order, sof on beat 0, eol on every 32nd beat, eof and done once.
REQ-039 pix_ready toggled pseudo-randomly -> no lost, duplicated or altered beats; outputs stable during stall.
REQ-040 continuous=1 for two frames -> beat 2047 (eof), one bubble, beat 0 (sof), done pulses twice.
REQ-041 reset asserted at beat 1000 -> next cycle pix_valid=0, busy=0, rd_address=0; new start restarts at (0,0).
REQ-042 Write mem[1500]=12'hABC at beat 100 -> beat 1500 carries 12'hABC.
REQ-043 start held high during the whole scan with continuous=0 -> exactly one frame, returns to IDLE.

Source files
------------

// File: rtl/stencil_reader.sv
// stencil_reader: raster-scans a stencil buffer and streams its pixels over a valid/ready port
// Ports: clock, reset (sync, active high); start requests one frame, continuous repeats frames;
// rd_address/rd_data form the buffer's combinational read port; pix_data/pix_x/pix_y/pix_sof/
// pix_eol/pix_eof are the registered beat qualified by pix_valid and accepted by pix_ready;
// busy is high outside IDLE; done pulses for one cycle per completed frame.
module stencil_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int X_WIDTH    = 5,
    parameter int Y_WIDTH    = 6,
    parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    output logic [ADDR_WIDTH-1:0] rd_address,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic [X_WIDTH-1:0]    pix_x,
    output logic [Y_WIDTH-1:0]    pix_y,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  pix_eof,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t state, state_next;
    logic first, load, last, finish;
    always_comb begin
        load = state == SCAN && !first && (!pix_valid || pix_ready);
        last = &rd_address;
        finish = state == DRAIN && pix_ready;
        state_next = state == IDLE ? (start ? SCAN : IDLE)
                   : state == SCAN ? (load && last ? DRAIN : SCAN)
                   : finish ? (continuous ? SCAN : IDLE) : DRAIN;
    end
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end
    assign busy = state != IDLE;
    // The first SCAN cycle after a start only presents address 0, so the first
    // pixel lands two edges after start; frames chained from DRAIN skip it.
    always_ff @(posedge clock) begin
        if (reset) begin
            first      <= 1'b0;
            rd_address <= '0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_eof    <= 1'b0;
            pix_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            first <= state == IDLE && start;
            done  <= finish;
            if (state == IDLE)
                rd_address <= '0;
            if (load) begin
                pix_data   <= rd_data;
                pix_x      <= rd_address[X_WIDTH-1:0];
                pix_y      <= Y_WIDTH'(rd_address >> X_WIDTH);
                pix_sof    <= rd_address == '0;
                pix_eol    <= &rd_address[X_WIDTH-1:0];
                pix_eof    <= last;
                pix_valid  <= 1'b1;
                rd_address <= rd_address + ADDR_WIDTH'(1);
            end else if (finish) begin
                pix_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stencil_reader.sv
// tb_stencil_reader: checks stencil_reader against a beat-index model of a row-major frame scan
module tb_stencil_reader;
    logic        clock = 0, reset = 1, start = 0, continuous = 0, pix_ready = 1;
    logic [10:0] rd_address;
    logic [11:0] rd_data, pix_data;
    logic [4:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_sof, pix_eol, pix_eof, pix_valid, busy, done;
    logic [11:0] mem [2048];
    logic [11:0] got [2048];
    int checks = 0, errors = 0;
    int k = 0, beats = 0, done_cnt = 0;
    logic rnd = 0;

    stencil_reader dut (
        .clock(clock), .reset(reset), .start(start), .continuous(continuous),
        .rd_address(rd_address), .rd_data(rd_data), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_eof(pix_eof), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .done(done)
    );

    assign rd_data = mem[rd_address];
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] expv(input int i);
        return {mem[i], 5'(i % 32), 6'(i / 32), i == 0, i % 32 == 31, i == 2047};
    endfunction

    function automatic logic [25:0] outv();
        return {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
    endfunction

    // per-cycle checker: beats must follow the scan order, hold during stalls,
    // never gap mid-frame, and a frame end gives done plus exactly one bubble
    initial begin
        logic stall_prev = 0, mid_prev = 0, eof_prev = 0, cont_eof = 0, bub_prev = 0;
        logic [25:0] held = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                k = 0; stall_prev = 0; mid_prev = 0; eof_prev = 0; bub_prev = 0;
            end else begin
                chk("done", done, eof_prev);
                if (done) done_cnt++;
                if (eof_prev) chk("bubble", pix_valid, 0);
                if (bub_prev) chk("restart", {pix_valid, pix_sof}, 2'b11);
                if (mid_prev) chk("nogap", pix_valid, 1);
                if (stall_prev) chk("stall", {pix_valid, outv()}, {1'b1, held});
                bub_prev = eof_prev && cont_eof;
                stall_prev = pix_valid && !pix_ready;
                held = outv();
                mid_prev = 0;
                eof_prev = 0;
                if (pix_valid && pix_ready) begin
                    chk("beat", outv(), expv(k));
                    got[k] = pix_data;
                    beats++;
                    mid_prev = k != 2047;
                    eof_prev = k == 2047;
                    cont_eof = continuous;
                    k = (k + 1) % 2048;
                end
            end
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        if (rnd) pix_ready = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_frames(input int n);
        int budget = 20000;
        while (done_cnt < n && budget > 0) begin
            tick();
            budget--;
        end
        chk("frame_timeout", done_cnt >= n, 1);
    endtask

    task automatic wait_beat(input int n);
        int budget = 10000;
        while (k < n && budget > 0) begin
            tick();
            budget--;
        end
        chk("beat_timeout", k >= n, 1);
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 12'(a);
        repeat (3) tick();
        chk("reset_state", {pix_valid, busy, done, rd_address, outv()}, '0);
        reset = 0;
        tick();
        // single frame with ready held high; start sampled at edge N
        start = 1;
        tick();
        start = 0;
        chk("lat_n", {busy, pix_valid}, 2'b10);
        tick();
        chk("lat_n1", pix_valid, 0);
        tick();
        chk("lat_n2", {pix_valid, pix_sof, pix_x, pix_y, pix_data}, {2'b11, 23'd0});
        beats = 0; done_cnt = 0;
        wait_frames(1);
        tick();
        chk("f1_beats", beats, 2048);
        chk("f1_first", got[0], 12'h000);
        chk("f1_last", got[2047], 12'h7FF);
        chk("f1_mid", got[1234], 12'h4D2);
        chk("f1_idle", {busy, pix_valid}, 2'b00);
        // random backpressure plus a buffer write ahead of the scan
        rnd = 1; beats = 0; done_cnt = 0;
        start = 1;
        tick();
        start = 0;
        wait_beat(100);
        mem[1500] = 12'hABC;
        wait_frames(1);
        rnd = 0; pix_ready = 1;
        tick();
        chk("f2_beats", beats, 2048);
        chk("f2_write", got[1500], 12'hABC);
        chk("f2_after", got[1501], 12'h5DD);
        mem[1500] = 12'd1500;
        // two chained frames in continuous mode
        beats = 0; done_cnt = 0;
        continuous = 1; start = 1;
        tick();
        start = 0;
        wait_frames(1);
        continuous = 0;
        wait_frames(2);
        repeat (3) tick();
        chk("cont_beats", beats, 4096);
        chk("cont_done", done_cnt, 2);
        chk("cont_idle", busy, 0);
        // reset in the middle of a frame
        start = 1;
        tick();
        start = 0;
        wait_beat(1000);
        reset = 1; start = 1; pix_ready = 1;
        tick();
        chk("rst_mid", {pix_valid, busy, done, rd_address}, '0);
        reset = 0; start = 0;
        tick();
        chk("rst_stay", busy, 0);
        beats = 0; done_cnt = 0;
        start = 1;
        tick();
        start = 0;
        tick();
        tick();
        chk("rst_restart", {pix_valid, pix_sof, pix_x, pix_y}, {2'b11, 11'd0});
        wait_frames(1);
        tick();
        chk("rst_beats", beats, 2048);
        // start held high for the whole frame
        beats = 0; done_cnt = 0;
        start = 1;
        begin
            int budget = 20000;
            while (!done && budget > 0) begin
                tick();
                budget--;
            end
        end
        start = 0;
        repeat (4) tick();
        chk("hold_frames", done_cnt, 1);
        chk("hold_beats", beats, 2048);
        chk("hold_idle", {busy, pix_valid}, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
